result_buffer_unload: RTL and testbench
=======================================

Name: result_buffer_unload

Overview:
- Output-side counterpart of the B-operand input buffer. That buffer takes serial elements and emits MMU_SIZE-wide rows to the MMU; this block does the reverse.
- Captures MMU result rows in parallel, one row per cycle, into a local bank of MMU_SIZE x MMU_SIZE accumulators.
- Later streams the stored matrix out serially, one element per cycle, in row-major order, toward the host/output interface.
- Sits between the MMU result port and the MPU output path. Shares the cmd/stop/dim conventions of the operand buffers.

Parameters:
- ACC_SIZE, 32, width of one signed accumulator result.
- VAR_SIZE, 8, operand width; used only by the saturation option.
- MMU_SIZE, 10, rows/columns of the systolic array and of the local bank.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd  in  2  00 NONE, 01 STORE, 10 READ, 11 CLEAR; sampled only in IDLE.
- stop  in  1  stall; freezes pointers and suppresses writes/output.
- C_in  in  ACC_SIZE*MMU_SIZE  signed result row from MMU; column j occupies bits [ACC_SIZE*(j+1)-1 : ACC_SIZE*j].
- dim_x_in  in  8  columns per row of the incoming result; latched on STORE.
- dim_y_in  in  8  rows of the incoming result; latched on STORE.
- D_out  out  ACC_SIZE  signed serial result element (registered).
- valid_out  out  1  D_out carries a new element this cycle.
- busy  out  1  state != IDLE.
- dim_x_out  out  8  latched column count.
- dim_y_out  out  8  latched row count.

Behaviour:
- Reset (any cycle, including mid-operation): state=IDLE, row_ptr=col_ptr=0, D_out=0, valid_out=0, dim_x_out=dim_y_out=0. Bank contents are not reset; CLEAR zeroes them.
- States: IDLE, STORE, READ, CLEAR.
- IDLE:
  - stop=1 or cmd=NONE: stay, nothing latched.
  - STORE: latch dims, each clamped to MMU_SIZE. Enter STORE with row_ptr=0. If either clamped dim is 0, latch the dims but stay IDLE.
  - READ: enter READ with row_ptr=col_ptr=0. If a latched dim is 0, stay IDLE and emit nothing.
  - CLEAR: dims<=0, enter CLEAR with row_ptr=0.
- STORE:
  - Each cycle with stop=0, write all MMU_SIZE columns of C_in to row row_ptr, then row_ptr++.
  - After the write of row dim_y-1, go to IDLE.
  - Columns >= dim_x are still written; their contents are don't-care.
  - stop=1: no write, row_ptr holds.
- READ:
  - Each cycle with stop=0, address element (row_ptr, col_ptr). On the next edge D_out<=element and valid_out<=1. Latency is 1 cycle from address to output.
  - col_ptr wraps at dim_x-1 to 0 with row_ptr++.
  - After address (dim_y-1, dim_x-1), go to IDLE. The last element's valid_out=1 appears in the first IDLE cycle.
  - stop=1: pointers hold, valid_out<=0 next cycle, D_out holds its value.
  - Total: exactly dim_x*dim_y valid beats, no gaps unless stalled.
- CLEAR:
  - Zero one full row per cycle, rows 0..MMU_SIZE-1 (MMU_SIZE cycles), then IDLE.
  - stop is ignored in CLEAR.
- valid_out is 0 in every cycle not immediately following a non-stalled READ address cycle.
- Pointers are 8-bit; no wrap beyond the clamped dims is possible.
- cmd changes outside IDLE are ignored.

Optional Feature:
- Macro RESULT_SAT_EN.
- Defined: each element is clamped to [-(2^(VAR_SIZE-1)), 2^(VAR_SIZE-1)-1] and sign-extended to ACC_SIZE before registering into D_out. Same latency.
- Undefined: raw ACC_SIZE value passes through unmodified.

Decomposition:
- Shared package mpu_pkg:
  - cmd encodings CMD_NONE/LOAD(STORE)/SEND(READ)/CLEAR.
  - state encodings IDLE/STORE/READ/CLEAR.
  - default MMU_SIZE/VAR_SIZE/ACC_SIZE constants.
- One sub-module, mem_2to1: MMU_SIZE x MMU_SIZE x ACC_SIZE storage with row-parallel write (row address, write enable, wide data) and single-element combinational read (row, col address). It is the mirror of the existing row-read memory.
- The FSM, pointers, saturation and output register stay in result_buffer_unload.

Test Plan:
- Reset mid-READ (rst=1 during the 3rd element of a 3x3 read): next cycle state=IDLE, valid_out=0, D_out=0, busy=0.
- STORE, dim_x=3, dim_y=2; C_in row0=(1,2,3), row1=(-4,5,6); then READ: D_out sequence 1,2,3,-4,5,6 on 6 consecutive valid beats. First beat 2 cycles after READ cmd; busy drops the cycle the last beat appears.
- READ of a 10x10 store with stop=1 pulsed for 2 cycles after beat 37: valid_out low for exactly 2 cycles, no element skipped or duplicated, 100 beats total.
- STORE with dim_y=12, dim_x=15: dim_x_out=dim_y_out=10, exactly 10 rows written, READ yields 100 beats. STORE with dim_y=0: busy never rises.
- CLEAR after a 4x4 store, then STORE dims 4x4 with C_in all zero except (3,3)=7: CLEAR takes 10 cycles, dim outputs 0 during it. READ then gives fifteen 0s and a final 7.
- With RESULT_SAT_EN, store values 300, -300, 127, -128 (VAR_SIZE=8): D_out = 127, -128, 127, -128. Without the macro: 300, -300, 127, -128.

Source files
------------

// File: rtl/mpu_pkg.sv
// rtl/mpu_pkg.sv - shared MPU command/state encodings, default sizes and dim clamp helper
package mpu_pkg;

  localparam int MMU_SIZE_DEF = 10;
  localparam int VAR_SIZE_DEF = 8;
  localparam int ACC_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_SEND  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_STORE = 2'b01,
    ST_READ  = 2'b10,
    ST_CLEAR = 2'b11
  } state_e;

  function automatic logic [7:0] clamp_dim(input logic [7:0] dim, input logic [7:0] max_dim);
    return (dim > max_dim) ? max_dim : dim;
  endfunction

endpackage

// File: rtl/result_buffer_unload_if.sv
// rtl/result_buffer_unload_if.sv - result buffer bus: command/dims/row in, serial element out
interface result_buffer_unload_if #(
  parameter int ACC_SIZE = 32,
  parameter int MMU_SIZE = 10
) ();

  logic [1:0]                   cmd;
  logic                         stop;
  logic [ACC_SIZE*MMU_SIZE-1:0] C_in;
  logic [7:0]                   dim_x_in;
  logic [7:0]                   dim_y_in;
  logic [ACC_SIZE-1:0]          D_out;
  logic                         valid_out;
  logic                         busy;
  logic [7:0]                   dim_x_out;
  logic [7:0]                   dim_y_out;

  modport master (
    output cmd, stop, C_in, dim_x_in, dim_y_in,
    input  D_out, valid_out, busy, dim_x_out, dim_y_out
  );

  modport slave (
    input  cmd, stop, C_in, dim_x_in, dim_y_in,
    output D_out, valid_out, busy, dim_x_out, dim_y_out
  );

endinterface

// File: rtl/result_buffer_unload_mem.sv
// rtl/result_buffer_unload_mem.sv - mem_2to1: row-parallel write, single-element combinational read
module mem_2to1 #(
  parameter int ACC_SIZE = 32,
  parameter int MMU_SIZE = 10,
  parameter int AW       = $clog2(MMU_SIZE)
) (
  input  logic                         clk,
  input  logic                         wr_en_i,
  input  logic [AW-1:0]                wr_row_i,
  input  logic [ACC_SIZE*MMU_SIZE-1:0] wr_data_i,
  input  logic [AW-1:0]                rd_row_i,
  input  logic [AW-1:0]                rd_col_i,
  output logic [ACC_SIZE-1:0]          rd_data_o
);

  // Storage is deliberately not reset; the owner zeroes it with full-row writes.
  logic [ACC_SIZE-1:0] mem_q [MMU_SIZE][MMU_SIZE];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int j = 0; j < MMU_SIZE; j++) begin
        mem_q[wr_row_i][j] <= wr_data_i[j*ACC_SIZE +: ACC_SIZE];
      end
    end
  end

  assign rd_data_o = mem_q[rd_row_i][rd_col_i];

endmodule

// File: rtl/result_buffer_unload.sv
// rtl/result_buffer_unload.sv - captures MMU result rows, streams them out row-major one element per cycle
// Optional macro RESULT_SAT_EN clamps each output element to the signed VAR_SIZE range.
module result_buffer_unload
  import mpu_pkg::*;
#(
  parameter int ACC_SIZE = ACC_SIZE_DEF,
  parameter int VAR_SIZE = VAR_SIZE_DEF,
  parameter int MMU_SIZE = MMU_SIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  result_buffer_unload_if.slave bus
);

  localparam int AW = $clog2(MMU_SIZE);
  localparam logic [7:0] MAX_DIM = 8'(MMU_SIZE);
`ifdef RESULT_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam logic signed [ACC_SIZE-1:0] SAT_MAX = ACC_SIZE'((1 << (VAR_SIZE - 1)) - 1);
  localparam logic signed [ACC_SIZE-1:0] SAT_MIN = ~SAT_MAX;

  state_e                       state_q;
  logic [7:0]                   row_ptr_q, col_ptr_q;
  logic [7:0]                   dim_x_q, dim_y_q;
  logic [ACC_SIZE-1:0]          d_out_q;
  logic                         valid_q;

  logic                         wr_en;
  logic [ACC_SIZE*MMU_SIZE-1:0] wr_data;
  logic [ACC_SIZE-1:0]          rd_data;
  logic signed [ACC_SIZE-1:0]   rd_elem, sat_elem, out_elem;

  // CLEAR reuses the row write port with zero data.
  assign wr_en   = ((state_q == ST_STORE) && !bus.stop) || (state_q == ST_CLEAR);
  assign wr_data = (state_q == ST_CLEAR) ? '0 : bus.C_in;

  mem_2to1 #(.ACC_SIZE(ACC_SIZE), .MMU_SIZE(MMU_SIZE), .AW(AW)) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_row_i  (row_ptr_q[AW-1:0]),
    .wr_data_i (wr_data),
    .rd_row_i  (row_ptr_q[AW-1:0]),
    .rd_col_i  (col_ptr_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  assign rd_elem = rd_data;

  always_comb begin
    sat_elem = rd_elem;
    if (rd_elem > SAT_MAX) begin
      sat_elem = SAT_MAX;
    end else if (rd_elem < SAT_MIN) begin
      sat_elem = SAT_MIN;
    end
  end

  assign out_elem = SAT_EN ? sat_elem : rd_elem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_ptr_q <= '0;
      col_ptr_q <= '0;
      dim_x_q   <= '0;
      dim_y_q   <= '0;
      d_out_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!bus.stop) begin
            case (cmd_e'(bus.cmd))
              CMD_LOAD: begin
                dim_x_q   <= clamp_dim(bus.dim_x_in, MAX_DIM);
                dim_y_q   <= clamp_dim(bus.dim_y_in, MAX_DIM);
                row_ptr_q <= '0;
                if ((bus.dim_x_in != 8'd0) && (bus.dim_y_in != 8'd0)) state_q <= ST_STORE;
              end
              CMD_SEND: begin
                row_ptr_q <= '0;
                col_ptr_q <= '0;
                if ((dim_x_q != 8'd0) && (dim_y_q != 8'd0)) state_q <= ST_READ;
              end
              CMD_CLEAR: begin
                dim_x_q   <= '0;
                dim_y_q   <= '0;
                row_ptr_q <= '0;
                state_q   <= ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
        ST_STORE: begin
          if (!bus.stop) begin
            if (row_ptr_q == dim_y_q - 8'd1) begin
              row_ptr_q <= '0;
              state_q   <= ST_IDLE;
            end else begin
              row_ptr_q <= row_ptr_q + 8'd1;
            end
          end
        end
        ST_READ: begin
          // Stall holds pointers and D_out; valid falls on the next edge.
          if (!bus.stop) begin
            d_out_q <= out_elem;
            valid_q <= 1'b1;
            if (col_ptr_q == dim_x_q - 8'd1) begin
              col_ptr_q <= '0;
              if (row_ptr_q == dim_y_q - 8'd1) begin
                row_ptr_q <= '0;
                state_q   <= ST_IDLE;
              end else begin
                row_ptr_q <= row_ptr_q + 8'd1;
              end
            end else begin
              col_ptr_q <= col_ptr_q + 8'd1;
            end
          end
        end
        ST_CLEAR: begin
          if (row_ptr_q == MAX_DIM - 8'd1) begin
            row_ptr_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            row_ptr_q <= row_ptr_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.D_out     = d_out_q;
  assign bus.valid_out = valid_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.dim_x_out = dim_x_q;
  assign bus.dim_y_out = dim_y_q;

endmodule

// File: tb/tb_result_buffer_unload.sv
// tb/tb_result_buffer_unload.sv - directed self-checking bench for result_buffer_unload
module tb_result_buffer_unload;
  import mpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  result_buffer_unload_if #(.ACC_SIZE(32), .MMU_SIZE(10)) bus ();

  result_buffer_unload dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic signed [31:0] img [10][10];
  logic [31:0]        beats[$];
  int                 gaps, first_t, end_ok, done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic [319:0] pack_row(input int r);
    logic [319:0] row = '0;
    if (r < 10) begin
      for (int c = 0; c < 10; c++) row[c*32 +: 32] = img[r][c];
    end
    return row;
  endfunction

  task automatic fill(input int base);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        img[r][c] = base + r * 10 + c;
  endtask

  task automatic store_run(input logic [7:0] dx, input logic [7:0] dy, output int rows);
    bus.cmd      = CMD_LOAD;
    bus.dim_x_in = dx;
    bus.dim_y_in = dy;
    tick();
    bus.cmd = CMD_NONE;
    rows = 0;
    while (bus.busy && rows < 20) begin
      bus.C_in = pack_row(rows);
      tick();
      rows++;
    end
    bus.C_in = '0;
  endtask

  task automatic read_run(input int stall_at);
    int t = 0;
    int stall_left = 0;
    bit stalled = 0;
    beats.delete();
    gaps = 0; first_t = 0; end_ok = 0; done = 0;
    bus.cmd = CMD_SEND;
    while (t < 400) begin
      tick();
      t++;
      bus.cmd = CMD_NONE;
      if (bus.valid_out) begin
        beats.push_back(bus.D_out);
        if (first_t == 0) first_t = t;
      end else if (beats.size() > 0 && bus.busy) begin
        gaps++;
      end
      if (!bus.busy) begin
        end_ok = int'(bus.valid_out);
        done = 1;
        break;
      end
      if (stall_at > 0 && beats.size() == stall_at && !stalled) begin
        stalled = 1;
        stall_left = 2;
      end
      bus.stop = (stall_left > 0);
      if (stall_left > 0) stall_left--;
    end
    bus.stop = 1'b0;
    check("read_terminated", 32'(done), 32'd1);
  endtask

  initial begin
    int rows, cycles, dimnz;
    int exp6[6];
    int sat_exp[4];
    bus.cmd = CMD_NONE; bus.stop = 1'b0; bus.C_in = '0;
    bus.dim_x_in = '0; bus.dim_y_in = '0;
    tick(); tick();
    rst = 1'b0;

    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_dout", bus.D_out, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_dimx", 32'(bus.dim_x_out), 32'd0);

    // 3x2 store and read
    fill(0);
    img[0][0] = 1;  img[0][1] = 2; img[0][2] = 3;
    img[1][0] = -4; img[1][1] = 5; img[1][2] = 6;
    store_run(8'd3, 8'd2, rows);
    check("t2_rows", 32'(rows), 32'd2);
    check("t2_dimx", 32'(bus.dim_x_out), 32'd3);
    check("t2_dimy", 32'(bus.dim_y_out), 32'd2);
    read_run(0);
    exp6 = '{1, 2, 3, -4, 5, 6};
    check("t2_count", 32'(beats.size()), 32'd6);
    for (int i = 0; i < 6 && i < beats.size(); i++)
      check($sformatf("t2_beat%0d", i), beats[i], 32'(exp6[i]));
    check("t2_latency", 32'(first_t), 32'd2);
    check("t2_busy_drop", 32'(end_ok), 32'd1);
    check("t2_gaps", 32'(gaps), 32'd0);

    // reset in the middle of a 3x3 read
    store_run(8'd3, 8'd3, rows);
    bus.cmd = CMD_SEND;
    tick();
    bus.cmd = CMD_NONE;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t3_valid", 32'(bus.valid_out), 32'd0);
    check("t3_dout", bus.D_out, 32'd0);
    check("t3_busy", 32'(bus.busy), 32'd0);
    check("t3_dimx", 32'(bus.dim_x_out), 32'd0);
    rst = 1'b0;
    tick();

    // 10x10 read with a two-cycle stall after beat 37
    fill(1);
    store_run(8'd10, 8'd10, rows);
    check("t4_rows", 32'(rows), 32'd10);
    read_run(37);
    check("t4_count", 32'(beats.size()), 32'd100);
    check("t4_gaps", 32'(gaps), 32'd2);
    for (int i = 0; i < 100 && i < beats.size(); i++)
      check($sformatf("t4_beat%0d", i), beats[i], 32'(i + 1));

    // oversized dims clamp to 10
    fill(1000);
    store_run(8'd15, 8'd12, rows);
    check("t5_rows", 32'(rows), 32'd10);
    check("t5_dimx", 32'(bus.dim_x_out), 32'd10);
    check("t5_dimy", 32'(bus.dim_y_out), 32'd10);
    read_run(0);
    check("t5_count", 32'(beats.size()), 32'd100);
    for (int i = 0; i < 100 && i < beats.size(); i++)
      check($sformatf("t5_beat%0d", i), beats[i], 32'(1000 + i));

    // zero dim_y never starts
    store_run(8'd5, 8'd0, rows);
    check("t6_rows", 32'(rows), 32'd0);
    check("t6_dimx", 32'(bus.dim_x_out), 32'd5);
    check("t6_dimy", 32'(bus.dim_y_out), 32'd0);
    read_run(0);
    check("t6_count", 32'(beats.size()), 32'd0);

    // CLEAR then sparse 4x4 store
    fill(9);
    store_run(8'd4, 8'd4, rows);
    bus.cmd = CMD_CLEAR;
    tick();
    bus.cmd = CMD_NONE;
    cycles = 0; dimnz = 0;
    while (bus.busy && cycles < 30) begin
      if (bus.dim_x_out != 0 || bus.dim_y_out != 0) dimnz = 1;
      tick();
      cycles++;
    end
    check("t7_clear_cycles", 32'(cycles), 32'd10);
    check("t7_clear_dims", 32'(dimnz), 32'd0);
    fill(0);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        img[r][c] = 0;
    img[3][3] = 7;
    store_run(8'd4, 8'd4, rows);
    read_run(0);
    check("t7_count", 32'(beats.size()), 32'd16);
    for (int i = 0; i < 16 && i < beats.size(); i++)
      check($sformatf("t7_beat%0d", i), beats[i], (i == 15) ? 32'd7 : 32'd0);

    // saturation option
    img[0][0] = 300; img[0][1] = -300; img[0][2] = 127; img[0][3] = -128;
    store_run(8'd4, 8'd1, rows);
    read_run(0);
`ifdef RESULT_SAT_EN
    sat_exp = '{127, -128, 127, -128};
`else
    sat_exp = '{300, -300, 127, -128};
`endif
    check("t8_count", 32'(beats.size()), 32'd4);
    for (int i = 0; i < 4 && i < beats.size(); i++)
      check($sformatf("t8_beat%0d", i), beats[i], 32'(sat_exp[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
